// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_if
// Purpose  : Pipeline handshake, bus and data-SRAM request bundle around the
//            execute stage. The master side is the EX stage itself; the slave
//            side is the surrounding pipeline (ID, MEM) and the SRAM.
// Revision : 1.0  initial release
// ============================================================================
interface ex_stage_if;
  logic         ex_allowin;
  logic         id_to_ex_valid;
  logic [154:0] id_to_ex_bus;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [138:0] ex_to_mem_bus;
  logic [38:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport master (
    input  id_to_ex_valid, id_to_ex_bus, mem_allowin,
    output ex_allowin, ex_to_mem_valid, ex_to_mem_bus, ex_to_id_bus,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output id_to_ex_valid, id_to_ex_bus, mem_allowin,
    input  ex_allowin, ex_to_mem_valid, ex_to_mem_bus, ex_to_id_bus,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage of the 5-stage in-order pipeline. Holds one
//            instruction from ID, computes the ALU result, runs a restoring
//            iterative divider for div/mod, and issues the data-SRAM request
//            on the EX->MEM transfer cycle.
//            alu_op is one-hot: [0] add [1] sub [2] slt [3] sltu [4] and
//            [5] nor [6] or [7] xor [8] sll [9] srl [10] sra [11] lui(src2).
// Revision : 1.0  initial release
// ============================================================================
module ex_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic       clk,
  input  logic       resetn,
  ex_stage_if.master io
);
  localparam int               CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // ---------------- instruction register ----------------
  logic         ex_valid_q, ex_valid_d;
  logic [154:0] bus_q, bus_d;

  logic [31:0] pc, src1, src2, rkd;
  logic [11:0] alu_op;
  logic        res_from_mem, rf_we, mem_en;
  logic [4:0]  rf_waddr;
  logic [3:0]  ld_st_type;
  logic        div_valid, div_signed, div_rem;

  assign {pc, alu_op, src1, src2, rkd, res_from_mem, rf_we, rf_waddr,
          mem_en, ld_st_type, div_valid, div_signed, div_rem} = bus_q;

  logic ex_ready_go, ex_allowin, accept;
  div_state_e div_state_q, div_state_d;

  assign ex_ready_go = ~div_valid | (div_state_q == DIV_DONE);
  assign ex_allowin  = ~ex_valid_q | (ex_ready_go & io.mem_allowin);
  assign accept      = io.id_to_ex_valid & ex_allowin;

  // Next-state of the stage: valid follows ID whenever EX can take a slot.
  always_comb begin
    ex_valid_d = ex_valid_q;
    bus_d      = bus_q;
    if (ex_allowin) ex_valid_d = io.id_to_ex_valid;
    if (accept)     bus_d      = io.id_to_ex_bus;
  end

  // Stage registers; payload needs no reset because valid qualifies it.
  always_ff @(posedge clk) begin
    if (!resetn) ex_valid_q <= 1'b0;
    else         ex_valid_q <= ex_valid_d;
    bus_q <= bus_d;
  end

  // ---------------- ALU ----------------
  logic [31:0] add_res, sub_res, sll_res, srl_res, sra_res, alu_result;
  logic        slt_res, sltu_res;

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = $signed(src1) < $signed(src2);
  assign sltu_res = src1 < src2;
  assign sll_res  = src1 << src2[4:0];
  assign srl_res  = src1 >> src2[4:0];
  assign sra_res  = 32'($signed(src1) >>> src2[4:0]);

  assign alu_result = ({32{alu_op[0]}}  & add_res)
                    | ({32{alu_op[1]}}  & sub_res)
                    | ({32{alu_op[2]}}  & {31'b0, slt_res})
                    | ({32{alu_op[3]}}  & {31'b0, sltu_res})
                    | ({32{alu_op[4]}}  & (src1 & src2))
                    | ({32{alu_op[5]}}  & ~(src1 | src2))
                    | ({32{alu_op[6]}}  & (src1 | src2))
                    | ({32{alu_op[7]}}  & (src1 ^ src2))
                    | ({32{alu_op[8]}}  & sll_res)
                    | ({32{alu_op[9]}}  & srl_res)
                    | ({32{alu_op[10]}} & sra_res)
                    | ({32{alu_op[11]}} & src2);

  // ---------------- divider ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [33:0]      trial;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor; bit 33 set means it did not fit.
  assign trial = {1'b0, rem_q, quo_q[31]} - {2'b00, divisor_q};

  // Divider FSM next state: magnitudes and sign flags are captured on entry,
  // quo_q doubles as the dividend shifter and the quotient accumulator.
  always_comb begin
    div_state_d = div_state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (ex_valid_q && div_valid) begin
          div_state_d = DIV_RUN;
          cnt_d       = '0;
          rem_d       = '0;
          quo_d       = (div_signed && src1[31]) ? -src1 : src1;
          divisor_d   = (div_signed && src2[31]) ? -src2 : src2;
          q_neg_d     = div_signed & (src1[31] ^ src2[31]);
          r_neg_d     = div_signed & src1[31];
        end
      end
      DIV_RUN: begin
        quo_d = {quo_q[30:0], ~trial[33]};
        rem_d = trial[33] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        if (cnt_q == CNT_LAST) div_state_d = DIV_DONE;
        else                   cnt_d       = cnt_q + 1'b1;
      end
      DIV_DONE: begin
        if (io.ex_to_mem_valid && io.mem_allowin) begin
          div_state_d = DIV_IDLE;
          cnt_d       = '0;
        end
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  // Divider registers; only control is reset, so reset aborts a division.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_state_q <= DIV_IDLE;
      cnt_q       <= '0;
    end else begin
      div_state_q <= div_state_d;
      cnt_q       <= cnt_d;
    end
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    divisor_q <= divisor_d;
    q_neg_q   <= q_neg_d;
    r_neg_q   <= r_neg_d;
  end

  logic [31:0] div_q, div_r, ex_result;

  // Sign fixup; a zero divisor returns all-ones and the untouched dividend.
  always_comb begin
    div_q = q_neg_q ? -quo_q : quo_q;
    div_r = r_neg_q ? -rem_q : rem_q;
    if (divisor_q == 32'd0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = src1;
    end
  end

  assign ex_result = div_valid ? (div_rem ? div_r : div_q) : alu_result;

  // ---------------- data SRAM request ----------------
  logic [3:0]  be_mask;
  logic [31:0] st_data;

  // Byte lanes and replicated store data from access size and address LSBs.
  always_comb begin
    be_mask = 4'b1111;
    st_data = rkd;
    case (ld_st_type[1:0])
      2'b00: begin
        be_mask = 4'b0001 << alu_result[1:0];
        st_data = {4{rkd[7:0]}};
      end
      2'b01: begin
        be_mask = alu_result[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rkd[15:0]}};
      end
      default: begin
        be_mask = 4'b1111;
        st_data = rkd;
      end
    endcase
  end

  // The request fires only on the transfer cycle so read data meets MEM.
  assign io.data_sram_en    = ex_valid_q & mem_en & ex_ready_go & io.mem_allowin;
  assign io.data_sram_we    = (io.data_sram_en & ld_st_type[2]) ? be_mask : 4'b0000;
  assign io.data_sram_addr  = alu_result;
  assign io.data_sram_wdata = st_data;

  // ---------------- stage outputs ----------------
  logic fwd_we, fwd_block;
  assign fwd_we    = ex_valid_q & rf_we;
  assign fwd_block = ex_valid_q & rf_we & (res_from_mem | ~ex_ready_go);

  assign io.ex_allowin      = ex_allowin;
  assign io.ex_to_mem_valid = ex_valid_q & ex_ready_go;
  assign io.ex_to_mem_bus   = {pc, res_from_mem, rf_we, rf_waddr, ex_result,
                               rkd, alu_result, ld_st_type};
  assign io.ex_to_id_bus    = {fwd_we, fwd_block, rf_waddr, ex_result};
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage: directed scenarios followed by
//            a randomized instruction stream compared against a reference
//            model of the stage's architectural results.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ex_stage_if bus_if ();
  ex_stage u_dut (.clk(clk), .resetn(resetn), .io(bus_if));

  typedef struct {
    logic [31:0] pc, src1, src2, rkd;
    int          op;
    logic        rfm, we, men;
    logic [4:0]  wa;
    logic [3:0]  lst;
    logic [2:0]  dv;
  } instr_t;

  typedef struct {
    logic [138:0] bus;
    logic [38:0]  fwd;
    logic         en;
    logic         store;
    logic [3:0]   we;
    logic [31:0]  wdata;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << sh;
      9:  return a >> sh;
      10: return 32'($signed(a) >>> sh);
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic sgn, input logic rem,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    return rem ? r : q;
  endfunction

  function automatic logic [154:0] pack(input instr_t i);
    logic [11:0] oh;
    oh = 12'b0;
    oh[i.op] = 1'b1;
    return {i.pc, oh, i.src1, i.src2, i.rkd, i.rfm, i.we, i.wa, i.men, i.lst, i.dv};
  endfunction

  function automatic exp_t model(input instr_t i);
    exp_t e;
    logic [31:0] addr, res;
    int nbytes, base;
    addr   = ref_alu(i.op, i.src1, i.src2);
    res    = i.dv[2] ? ref_div(i.dv[1], i.dv[0], i.src1, i.src2) : addr;
    e.bus  = {i.pc, i.rfm, i.we, i.wa, res, i.rkd, addr, i.lst};
    e.fwd  = {i.we, i.we & i.rfm, i.wa, res};
    e.en   = i.men;
    e.store = i.men & i.lst[2];
    nbytes = (i.lst[1:0] == 2'b00) ? 1 : (i.lst[1:0] == 2'b01) ? 2 : 4;
    base   = int'(addr[1:0]) & ~(nbytes - 1);
    for (int b = 0; b < 4; b++) begin
      e.we[b] = e.store && (b >= base) && (b < base + nbytes);
      e.wdata[8*b +: 8] = i.rkd[8*(b % nbytes) +: 8];
    end
    return e;
  endfunction

  function automatic instr_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] dv);
    instr_t i;
    i.pc = 32'h1C00_0100; i.src1 = a; i.src2 = b; i.rkd = 32'd0; i.op = op;
    i.rfm = 1'b0; i.we = 1'b1; i.men = 1'b0; i.wa = 5'd3; i.lst = 4'b0011; i.dv = dv;
    return i;
  endfunction

  function automatic instr_t rand_instr(input int n);
    instr_t i;
    int kind, k;
    logic [1:0] sz;
    kind = $urandom_range(0, 9);
    k    = $urandom_range(0, 2);
    sz   = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
    i.pc = 32'h1C00_0000 + 32'(n * 4);
    i.src1 = $urandom; i.src2 = $urandom; i.rkd = $urandom;
    i.op = $urandom_range(0, 11);
    i.rfm = 1'b0; i.we = 1'($urandom_range(0, 1)); i.wa = 5'($urandom);
    i.men = 1'b0; i.lst = 4'($urandom); i.dv = 3'b000;
    if (kind == 6 || kind == 7) begin
      i.op = 0; i.rfm = 1'b1; i.we = 1'b1; i.men = 1'b1;
      i.lst = {1'($urandom_range(0, 1)), 1'b0, sz};
    end else if (kind == 8) begin
      i.op = 0; i.we = 1'b0; i.men = 1'b1; i.lst = {2'b01, sz};
    end else if (kind == 9) begin
      i.dv = {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      k = $urandom_range(0, 5);
      if (k == 0) i.src2 = 32'd0;
      if (k == 1) begin i.src1 = 32'h8000_0000; i.src2 = 32'hFFFF_FFFF; end
      if (k == 2) i.src2 = 32'($urandom_range(1, 20));
    end
    return i;
  endfunction

  // ---------------- drive helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input instr_t i);
    bit acc;
    acc = 1'b0;
    bus_if.id_to_ex_valid = 1'b1;
    bus_if.id_to_ex_bus   = pack(i);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus_if.ex_allowin;
      step();
    end
    bus_if.id_to_ex_valid = 1'b0;
    check("issue_accept", acc, 1'b1);
  endtask

  task automatic run_div(input instr_t i, output int lat, output logic [31:0] res,
                         output logic blk1, output logic blk_end);
    lat = 0; res = '0; blk1 = 1'b0; blk_end = 1'b0;
    issue(i);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) blk1 = bus_if.ex_to_id_bus[37];
      if (bus_if.ex_to_mem_valid) begin
        lat = k; res = bus_if.ex_to_mem_bus[99:68]; blk_end = bus_if.ex_to_id_bus[37];
        break;
      end
      step();
    end
    step();
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr_t i, cur;
    exp_t e;
    int lat, issued;
    bit have;
    logic [31:0] res;
    logic blk1, blk_end;

    resetn = 1'b0;
    bus_if.id_to_ex_valid = 1'b0;
    bus_if.id_to_ex_bus   = '0;
    bus_if.mem_allowin    = 1'b1;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("rst_valid", bus_if.ex_to_mem_valid, 1'b0);
    check("rst_en", bus_if.data_sram_en, 1'b0);
    check("rst_we", bus_if.data_sram_we, 4'b0);
    check("rst_fwd", bus_if.ex_to_id_bus[38:37], 2'b00);
    check("rst_allowin", bus_if.ex_allowin, 1'b1);
    step();
    resetn = 1'b1;
    step();

    // add 5 + 7
    issue(mk(0, 32'd5, 32'd7, 3'b000));
    @(negedge clk);
    check("add_valid", bus_if.ex_to_mem_valid, 1'b1);
    check("add_result", bus_if.ex_to_mem_bus[99:68], 32'd12);
    check("add_fwd_we", bus_if.ex_to_id_bus[38], 1'b1);
    check("add_fwd_block", bus_if.ex_to_id_bus[37], 1'b0);
    check("add_en", bus_if.data_sram_en, 1'b0);
    step();

    // st.b / st.h
    i = mk(0, 32'h1000, 32'd3, 3'b000);
    i.we = 1'b0; i.men = 1'b1; i.lst = 4'b0100; i.rkd = 32'h1234_5678;
    issue(i);
    @(negedge clk);
    check("stb_en", bus_if.data_sram_en, 1'b1);
    check("stb_we", bus_if.data_sram_we, 4'b1000);
    check("stb_wdata", bus_if.data_sram_wdata, 32'h7878_7878);
    check("stb_addr", bus_if.data_sram_addr, 32'h1003);
    step();
    i.src2 = 32'd2; i.lst = 4'b0101;
    issue(i);
    @(negedge clk);
    check("sth_we", bus_if.data_sram_we, 4'b1100);
    check("sth_wdata", bus_if.data_sram_wdata, 32'h5678_5678);
    step();

    // signed div / mod -7 / 2
    run_div(mk(0, 32'hFFFF_FFF9, 32'd2, 3'b110), lat, res, blk1, blk_end);
    check("divw_lat", lat, 34);
    check("divw_q", res, 32'hFFFF_FFFD);
    check("divw_blk_run", blk1, 1'b1);
    check("divw_blk_done", blk_end, 1'b0);
    run_div(mk(0, 32'hFFFF_FFF9, 32'd2, 3'b111), lat, res, blk1, blk_end);
    check("modw_lat", lat, 34);
    check("modw_r", res, 32'hFFFF_FFFF);

    // divide by zero and signed overflow
    run_div(mk(0, 32'd100, 32'd0, 3'b100), lat, res, blk1, blk_end);
    check("divu_zero_q", res, 32'hFFFF_FFFF);
    run_div(mk(0, 32'd100, 32'd0, 3'b101), lat, res, blk1, blk_end);
    check("modu_zero_r", res, 32'd100);
    run_div(mk(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'b110), lat, res, blk1, blk_end);
    check("div_ovf_q", res, 32'h8000_0000);
    run_div(mk(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'b111), lat, res, blk1, blk_end);
    check("mod_ovf_r", res, 32'd0);

    // ld.w under backpressure
    i = mk(0, 32'h2000, 32'd4, 3'b000);
    i.rfm = 1'b1; i.men = 1'b1; i.lst = 4'b0011;
    e = model(i);
    bus_if.mem_allowin = 1'b0;
    issue(i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ldw_hold_en", bus_if.data_sram_en, 1'b0);
      check("ldw_hold_allowin", bus_if.ex_allowin, 1'b0);
      check("ldw_hold_bus", bus_if.ex_to_mem_bus, e.bus);
      step();
    end
    bus_if.mem_allowin = 1'b1;
    @(negedge clk);
    check("ldw_release_en", bus_if.data_sram_en, 1'b1);
    check("ldw_release_we", bus_if.data_sram_we, 4'b0000);
    step();
    @(negedge clk);
    check("ldw_after_en", bus_if.data_sram_en, 1'b0);
    step();

    // reset in the middle of a division, then a fresh one
    issue(mk(0, 32'd1000, 32'd7, 3'b110));
    repeat (11) step();
    resetn = 1'b0;
    step();
    @(negedge clk);
    check("abort_valid", bus_if.ex_to_mem_valid, 1'b0);
    check("abort_allowin", bus_if.ex_allowin, 1'b1);
    check("abort_fwd", bus_if.ex_to_id_bus[38:37], 2'b00);
    step();
    resetn = 1'b1;
    step();
    run_div(mk(0, 32'd1000, 32'd7, 3'b110), lat, res, blk1, blk_end);
    check("fresh_div_lat", lat, 34);
    check("fresh_div_q", res, 32'd142);

    // randomized stream with random backpressure
    issued = 0;
    have   = 1'b0;
    for (int cyc = 0; cyc < 20000 && (issued < 80 || have || exp_q.size() > 0); cyc++) begin
      step();
      bus_if.mem_allowin = ($urandom_range(0, 3) != 0);
      if (!have && issued < 80 && $urandom_range(0, 2) != 0) begin
        cur = rand_instr(issued);
        issued++;
        have = 1'b1;
      end
      bus_if.id_to_ex_valid = have;
      if (have) bus_if.id_to_ex_bus = pack(cur);
      @(negedge clk);
      if (bus_if.ex_to_mem_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious_valid", bus_if.ex_to_mem_valid, 1'b0);
        end else begin
          check("rnd_bus", bus_if.ex_to_mem_bus, exp_q[0].bus);
          check("rnd_fwd", bus_if.ex_to_id_bus, exp_q[0].fwd);
          if (bus_if.mem_allowin) begin
            check("rnd_en", bus_if.data_sram_en, exp_q[0].en);
            check("rnd_we", bus_if.data_sram_we, exp_q[0].we);
            if (exp_q[0].store) check("rnd_wdata", bus_if.data_sram_wdata, exp_q[0].wdata);
            void'(exp_q.pop_front());
          end else begin
            check("rnd_stall_en", bus_if.data_sram_en, 1'b0);
          end
        end
      end else begin
        check("rnd_idle_en", bus_if.data_sram_en, 1'b0);
      end
      if (have && bus_if.ex_allowin) begin
        exp_q.push_back(model(cur));
        have = 1'b0;
      end
    end
    bus_if.id_to_ex_valid = 1'b0;
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_issued", issued, 80);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
